// File: rtl/inert_seq_rd.sv
// Inertial-sensor SPI sequencer: wake delay, configuration writes, then
// one read burst of NUM_CH low/high byte pairs per sensor interrupt.
// Latency: INT to first spi_wrt is 3 clk; vld follows the final spi_done by 1 clk.
// Backpressure: one SPI transaction at a time, paced only by spi_done; INT arriving mid-burst raises ovr.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   INT            asynchronous sensor data-ready level
//   spi_done       end-of-transaction pulse from the SPI master
//   spi_rd         read data from the SPI master, low byte used, valid with spi_done
//   spi_wrt        transaction start pulse
//   spi_cmd        command word, non-zero only while a transaction is outstanding
//   data           snapshot of all channels, channel c at [c*16+:16] as {high, low}
//   vld            one-cycle pulse when data is updated
//   rdy            high once configuration is complete
//   ovr            one-cycle pulse when INT rises during a read burst
module inert_seq_rd #(
  parameter int                      NUM_INIT  = 4,
  parameter logic [NUM_INIT*16-1:0]  INIT_CMDS = {16'h1460, 16'h1150, 16'h1053, 16'h0D02},
  parameter int                      NUM_CH    = 2,
  parameter logic [NUM_CH*7-1:0]     RD_ADDRS  = {7'h2C, 7'h22},
  parameter int                      WAKE_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   INT,
  input  logic                   spi_done,
  input  logic [15:0]            spi_rd,
  output logic                   spi_wrt,
  output logic [15:0]            spi_cmd,
  output logic [NUM_CH*16-1:0]   data,
  output logic                   vld,
  output logic                   rdy,
  output logic                   ovr
);

  typedef enum logic [1:0] {S_WAKE, S_INIT, S_WAIT, S_READ} state_t;

  localparam logic [2:0] ILAST = 3'(NUM_INIT - 1);
  localparam logic [3:0] KLAST = 4'(2 * NUM_CH - 1);

  state_t                 state_q;
  logic                   int_s1_q, int_s_q, int_e_q;
  logic [WAKE_BITS-1:0]   wake_q, wake_d;
  logic [2:0]             idx_q;
  logic [3:0]             k_q;
  logic                   busy_q;
  logic [NUM_CH*16-1:0]   shadow_q, shadow_d;
  logic [NUM_CH*16-1:0]   data_q;
  logic                   wrt_q, vld_q, rdy_q, ovr_q;
  logic [15:0]            cmd_q;
  logic                   done_ok, int_rise;
  logic                   unused_rd;

  // Only the low byte of each SPI read carries register data.
  assign unused_rd = ^spi_rd[15:8];

  function automatic logic [15:0] init_cmd(input logic [2:0] i);
    logic [15:0] c;
    c = '0;
    for (int n = 0; n < NUM_INIT; n++)
      if (i == 3'(n)) c = INIT_CMDS[n*16 +: 16];
    return c;
  endfunction

  // Byte k reads channel k/2; odd bytes hit the next (high-byte) register,
  // with the address wrapping inside 7 bits.
  function automatic logic [15:0] rd_cmd(input logic [3:0] k);
    logic [6:0] a;
    a = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (k[3:1] == 3'(c)) a = RD_ADDRS[c*7 +: 7];
    return {1'b1, a + {6'd0, k[0]}, 8'h00};
  endfunction

  // A done with nothing outstanding is stray and ignored.
  assign done_ok  = spi_done & busy_q;
  assign int_rise = int_s_q & ~int_e_q;
  assign wake_d   = wake_q + WAKE_BITS'(1);

  // Shadow with the byte arriving this cycle merged in, so the final byte
  // and the data snapshot can be committed on the same edge.
  always_comb begin
    shadow_d = shadow_q;
    for (int b = 0; b < 2 * NUM_CH; b++)
      if (k_q == 4'(b)) shadow_d[b*8 +: 8] = spi_rd[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_WAKE;
      int_s1_q <= 1'b0;
      int_s_q  <= 1'b0;
      int_e_q  <= 1'b0;
      wake_q   <= '0;
      idx_q    <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      shadow_q <= '0;
      data_q   <= '0;
      wrt_q    <= 1'b0;
      cmd_q    <= '0;
      vld_q    <= 1'b0;
      rdy_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      int_s1_q <= INT;
      int_s_q  <= int_s1_q;
      int_e_q  <= int_s_q;
      wrt_q    <= 1'b0;
      vld_q    <= 1'b0;
      ovr_q    <= int_rise && (state_q == S_READ);
      // Retire the current transaction; a same-cycle restart below overrides this.
      if (done_ok) begin
        busy_q <= 1'b0;
        cmd_q  <= '0;
      end
      case (state_q)
        S_WAKE: begin
          wake_q <= wake_d;
          if (&wake_d) begin
            wrt_q   <= 1'b1;
            cmd_q   <= init_cmd(3'd0);
            busy_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          if (done_ok) begin
            if (idx_q < ILAST) begin
              idx_q  <= idx_q + 3'd1;
              wrt_q  <= 1'b1;
              cmd_q  <= init_cmd(idx_q + 3'd1);
              busy_q <= 1'b1;
            end else begin
              rdy_q   <= 1'b1;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (int_s_q) begin
            wrt_q   <= 1'b1;
            cmd_q   <= rd_cmd(4'd0);
            busy_q  <= 1'b1;
            k_q     <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          if (done_ok) begin
            shadow_q <= shadow_d;
            if (k_q != KLAST) begin
              k_q    <= k_q + 4'd1;
              wrt_q  <= 1'b1;
              cmd_q  <= rd_cmd(k_q + 4'd1);
              busy_q <= 1'b1;
            end else begin
              data_q  <= shadow_d;
              vld_q   <= 1'b1;
              state_q <= S_WAIT;
            end
          end
        end
        default: state_q <= S_WAKE;
      endcase
    end
  end

  assign spi_wrt = wrt_q;
  assign spi_cmd = cmd_q;
  assign data    = data_q;
  assign vld     = vld_q;
  assign rdy     = rdy_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_inert_seq_rd.sv
`timescale 1ns/1ps
module tb_inert_seq_rd;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, int_a, int_b;
  logic        done_a = 1'b0, done_b = 1'b0;
  logic [15:0] rd_a = '0, rd_b = '0;
  logic        wrt_a, wrt_b, vld_a, vld_b, rdy_a, rdy_b, ovr_a, ovr_b;
  logic [15:0] cmd_a, cmd_b;
  logic [31:0] data_a;
  logic [47:0] data_b;

  inert_seq_rd #(.WAKE_BITS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .INT(int_a), .spi_done(done_a), .spi_rd(rd_a),
    .spi_wrt(wrt_a), .spi_cmd(cmd_a), .data(data_a), .vld(vld_a), .rdy(rdy_a), .ovr(ovr_a));

  inert_seq_rd #(.NUM_CH(3), .RD_ADDRS({7'h7F, 7'h2C, 7'h22}), .WAKE_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .INT(int_b), .spi_done(done_b), .spi_rd(rd_b),
    .spi_wrt(wrt_b), .spi_cmd(cmd_b), .data(data_b), .vld(vld_b), .rdy(rdy_b), .ovr(ovr_b));

  typedef struct {logic [15:0] cmd; bit b2b;} exp_cmd_t;

  exp_cmd_t    exp_cmd_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  rsp_a_q[$], rsp_b_q[$];
  logic [15:0] b_cmds[$];
  int          checks = 0, errors = 0;
  int          wrt_cnt = 0, vld_cnt = 0, ovr_cnt = 0, vld_b_cnt = 0;
  logic [31:0] model_data = '0;
  bit          a_busy = 0, b_busy = 0;
  logic [15:0] a_cmd = '0;
  int          a_cnt = 0, b_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_of(input int which);
    case (which)
      0: return wrt_cnt;
      1: return vld_cnt;
      2: return int'(rdy_a);
      3: return vld_b_cnt;
      4: return int'(rdy_b);
      default: return b_cmds.size();
    endcase
  endfunction

  task automatic wait_until(input string tag, input int which, input int target, input int budget);
    int i;
    i = 0;
    while (i < budget && cnt_of(which) < target) begin
      @(posedge clk); #1;
      i++;
    end
    chk(tag, cnt_of(which) >= target, 1);
  endtask

  task automatic push_cmd(input logic [15:0] c, input bit b2b);
    exp_cmd_t e;
    e.cmd = c;
    e.b2b = b2b;
    exp_cmd_q.push_back(e);
  endtask

  task automatic push_init();
    push_cmd(16'h0D02, 0);
    push_cmd(16'h1053, 1);
    push_cmd(16'h1150, 1);
    push_cmd(16'h1460, 1);
  endtask

  task automatic push_burst(input logic [7:0] b0, b1, b2, b3, input logic [31:0] d);
    rsp_a_q.push_back(b0); rsp_a_q.push_back(b1);
    rsp_a_q.push_back(b2); rsp_a_q.push_back(b3);
    push_cmd(16'hA200, 0);
    push_cmd(16'hA300, 1);
    push_cmd(16'hAC00, 1);
    push_cmd(16'hAD00, 1);
    exp_data_q.push_back(d);
  endtask

  // SPI model and scoreboard for the default-parameter instance.
  always @(negedge clk) begin
    exp_cmd_t e;
    bit done_now, issued;
    if (!rst_n) begin
      a_busy = 0; a_cnt = 0; done_a = 1'b0;
      rsp_a_q.delete();
      model_data = '0;
    end else begin
      done_now = done_a;
      issued = 0;
      if (done_now) a_busy = 0;
      if (vld_a) begin
        vld_cnt++;
        chk("vld_after_done", done_now, 1);
        chk("vld_expected", exp_data_q.size() > 0, 1);
        if (exp_data_q.size() > 0) begin
          model_data = exp_data_q.pop_front();
          chk("data", data_a, model_data);
        end
      end else begin
        chk("data_hold", data_a, model_data);
      end
      if (wrt_a) begin
        wrt_cnt++;
        issued = 1;
        chk("one_outstanding", a_busy, 0);
        chk("wrt_expected", exp_cmd_q.size() > 0, 1);
        if (exp_cmd_q.size() > 0) begin
          e = exp_cmd_q.pop_front();
          chk("cmd", cmd_a, e.cmd);
          if (e.b2b) chk("zero_gap", done_now, 1);
        end
        a_busy = 1; a_cmd = cmd_a; a_cnt = 2;
      end else if (a_busy) begin
        chk("cmd_held", cmd_a, a_cmd);
      end else begin
        chk("cmd_idle", cmd_a, 0);
      end
      if (ovr_a) ovr_cnt++;
      done_a = 1'b0;
      if (a_busy && !issued) begin
        a_cnt--;
        if (a_cnt == 0) begin
          done_a = 1'b1;
          if (rsp_a_q.size() > 0) rd_a = {8'h5A, rsp_a_q.pop_front()};
          else rd_a = 16'h5A00;
        end
      end
    end
  end

  // SPI model for the three-channel instance; it only logs commands.
  always @(negedge clk) begin
    if (!rst_n) begin
      b_busy = 0; b_cnt = 0; done_b = 1'b0;
    end else begin
      if (done_b) b_busy = 0;
      done_b = 1'b0;
      if (vld_b) vld_b_cnt++;
      if (wrt_b) begin
        b_cmds.push_back(cmd_b);
        b_busy = 1; b_cnt = 2;
      end else if (b_busy && b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) begin
          done_b = 1'b1;
          if (rsp_b_q.size() > 0) rd_b = {8'h00, rsp_b_q.pop_front()};
          else rd_b = 16'h0000;
        end
      end
    end
  end

  initial begin
    int n, base;
    logic [15:0] bexp [6];
    bexp = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00, 16'hFF00, 16'h8000};
    rst_n = 1'b0; int_a = 1'b0; int_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wrt", wrt_a, 0);  chk("rst_cmd", cmd_a, 0);  chk("rst_data", data_a, 0);
    chk("rst_vld", vld_a, 0);  chk("rst_rdy", rdy_a, 0);  chk("rst_ovr", ovr_a, 0);

    // Power-up: wake delay then four back-to-back configuration writes.
    push_init();
    rst_n = 1'b1;
    n = 0;
    while (n < 40 && wrt_a !== 1'b1) begin @(posedge clk); #1; n++; end
    chk("wake_latency", n, 15);
    wait_until("rdy_rise", 2, 1, 100);
    chk("rdy_1clk_after_done", done_a, 1);
    chk("init_cmds_consumed", exp_cmd_q.size(), 0);

    // First burst.
    push_burst(8'h34, 8'h12, 8'hCD, 8'hAB, 32'hABCD_1234);
    int_a = 1'b1;
    n = 0;
    while (n < 20 && wrt_a !== 1'b1) begin @(posedge clk); #1; n++; end
    chk("int_latency", n, 3);
    int_a = 1'b0;
    wait_until("burst1_vld", 1, 1, 60);
    repeat (10) @(posedge clk);
    #1;
    chk("burst1_single_vld", vld_cnt, 1);
    chk("burst1_txns", wrt_cnt, 8);

    // Overrun during burst 2; INT held high so burst 3 follows directly.
    push_burst(8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF);
    push_burst(8'h11, 8'h22, 8'h33, 8'h44, 32'h4433_2211);
    base = wrt_cnt;
    int_a = 1'b1;
    wait_until("b2_start", 0, base + 1, 20);
    int_a = 1'b0;
    wait_until("b2_second", 0, base + 2, 20);
    int_a = 1'b1;
    wait_until("b3_start", 0, base + 5, 60);
    int_a = 1'b0;
    wait_until("b3_vld", 1, 3, 60);
    repeat (10) @(posedge clk);
    #1;
    chk("ovr_pulses", ovr_cnt, 1);
    chk("b2b3_txns", wrt_cnt - base, 8);
    chk("vld_total", vld_cnt, 3);

    // Reset between the 2nd and 3rd read of a burst.
    rsp_a_q.push_back(8'h55); rsp_a_q.push_back(8'h66);
    push_cmd(16'hA200, 0);
    push_cmd(16'hA300, 1);
    base = wrt_cnt;
    int_a = 1'b1;
    wait_until("b4_second", 0, base + 2, 30);
    rst_n = 1'b0; int_a = 1'b0;
    #1;
    chk("mid_rst_wrt", wrt_a, 0);  chk("mid_rst_cmd", cmd_a, 0);  chk("mid_rst_data", data_a, 0);
    chk("mid_rst_vld", vld_a, 0);  chk("mid_rst_rdy", rdy_a, 0);  chk("mid_rst_ovr", ovr_a, 0);
    repeat (3) @(posedge clk);
    #1;
    push_init();
    rst_n = 1'b1;
    wait_until("rdy_replay", 2, 1, 100);
    chk("replay_init_consumed", exp_cmd_q.size(), 0);
    chk("no_vld_before_burst", vld_cnt, 3);
    push_burst(8'h01, 8'h02, 8'h03, 8'h04, 32'h0403_0201);
    int_a = 1'b1;
    wait_until("b5_start", 0, wrt_cnt + 1, 20);
    int_a = 1'b0;
    wait_until("b5_vld", 1, 4, 60);

    // Three channels, last channel address wraps from 7'h7F to 7'h00.
    wait_until("b_rdy", 4, 1, 100);
    base = b_cmds.size();
    for (int i = 1; i <= 6; i++) rsp_b_q.push_back(8'(i));
    int_b = 1'b1;
    wait_until("b_start", 5, base + 1, 20);
    int_b = 1'b0;
    wait_until("b_vld", 3, 1, 80);
    chk("b_ncmds", b_cmds.size() - base, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("b_cmd%0d", i), b_cmds[base + i], bexp[i]);
    chk("b_data", data_b, 48'h0605_0403_0201);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
